// File: rtl/pc16_pkg.sv
// Shared types and helpers for the pc16_jump program counter: FSM states,
// Hack jump-code constants and the jump-condition decode.
package pc16_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam logic [2:0] JGT = 3'b001;
    localparam logic [2:0] JEQ = 3'b010;
    localparam logic [2:0] JGE = 3'b011;
    localparam logic [2:0] JLT = 3'b100;
    localparam logic [2:0] JNE = 3'b101;
    localparam logic [2:0] JLE = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    // j1 tests negative, j2 tests zero, j3 tests strictly positive.
    function automatic logic jump_cond(input logic [2:0] jmp, input logic zr, input logic ng);
        return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/pc16_jump_ret_stack.sv
// ret_stack: parameterised LIFO holding return addresses for pc16_jump.
// Only the count is reset; entry contents are don't-care until written.
module ret_stack #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;

    // With DEPTH a power of two the low bits of count wrap to the right slot when full.
    assign wr_idx_s = count_r[AW-1:0];
    assign rd_idx_s = count_r[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

    assign dout  = mem_r[rd_idx_s];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

    // Entry storage: written on push only.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_r[wr_idx_s] <= din;
        end
    end

    // Occupancy count; push wins if a caller ever asserts both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (push && !full) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else if (pop && !empty) begin
            count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/pc16_jump.sv
// pc16_jump: Hack-style program counter with jump decode, call/return stack
// and sticky fault. Optional macro PC16_JUMP_HALT_DETECT_EN adds a halted output.
module pc16_jump
    import pc16_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jmp_en,
    input  logic [2:0]  jmp,
    input  logic        zr,
    input  logic        ng,
    input  logic [15:0] target,
    input  logic        call,
    input  logic        ret,
    output logic [15:0] pc,
    output logic        taken,
    output logic        stack_empty,
    output logic        stack_full,
    output logic        fault
`ifdef PC16_JUMP_HALT_DETECT_EN
    ,
    output logic        halted
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t         state_r;
    logic           act_s;
    logic           push_s;
    logic           pop_s;
    logic           jump_s;
    logic           full_s;
    logic           empty_s;
    logic [15:0]    top_s;
    logic [CW-1:0]  count_s;

    assign act_s  = (state_r == RUN) & ~stall;
    assign push_s = act_s & call & ~ret & ~full_s;
    assign pop_s  = act_s & ret & ~call & ~empty_s;
    assign jump_s = jmp_en & jump_cond(jmp, zr, ng);

    assign stack_empty = (count_s == {CW{1'b0}});
    assign stack_full  = (count_s == CW'(DEPTH));

    ret_stack #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (pc + 16'd1),
        .dout  (top_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next-PC selection and fault tracking; all block outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
            pc      <= RESET_PC;
            taken   <= 1'b0;
            fault   <= 1'b0;
`ifdef PC16_JUMP_HALT_DETECT_EN
            halted  <= 1'b0;
`endif
        end else begin
            case (state_r)
                RUN: begin
                    if (stall) begin
                        pc    <= pc;
                        taken <= taken;
                    end else if ((call && ret) || (ret && empty_s) || (call && !ret && full_s)) begin
                        state_r <= FAULT;
                        fault   <= 1'b1;
                        taken   <= 1'b0;
                    end else if (ret) begin
                        pc    <= top_s;
                        taken <= 1'b1;
                    end else if (call || jump_s) begin
                        pc    <= target;
                        taken <= 1'b1;
`ifdef PC16_JUMP_HALT_DETECT_EN
                        // "@END; 0;JMP" idiom: a taken jump back onto itself.
                        if (!call && (target == pc)) begin
                            halted <= 1'b1;
                        end else begin
                            halted <= halted;
                        end
`endif
                    end else begin
                        pc    <= pc + 16'd1;
                        taken <= 1'b0;
                    end
                end
                FAULT: begin
                    fault <= 1'b1;
                    taken <= 1'b0;
                end
                default: begin
                    state_r <= FAULT;
                    fault   <= 1'b1;
                    taken   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc16_jump.sv
// Self-checking bench for pc16_jump: directed steps from the test plan followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_pc16_jump;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jmp_en;
    logic [2:0]  jmp;
    logic        zr;
    logic        ng;
    logic [15:0] target;
    logic        call;
    logic        ret;
    logic [15:0] pc;
    logic        taken;
    logic        stack_empty;
    logic        stack_full;
    logic        fault;
`ifdef PC16_JUMP_HALT_DETECT_EN
    logic        halted;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic        m_taken;
    logic        m_fault;
    logic        m_halt;
    logic [15:0] m_stk[$];

    pc16_jump #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .jmp_en      (jmp_en),
        .jmp         (jmp),
        .zr          (zr),
        .ng          (ng),
        .target      (target),
        .call        (call),
        .ret         (ret),
        .pc          (pc),
        .taken       (taken),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .fault       (fault)
`ifdef PC16_JUMP_HALT_DETECT_EN
        ,
        .halted      (halted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".taken"}, {15'd0, taken}, {15'd0, m_taken});
        chk({tag, ".empty"}, {15'd0, stack_empty}, {15'd0, m_stk.size() == 0});
        chk({tag, ".full"}, {15'd0, stack_full}, {15'd0, m_stk.size() == DEPTH});
        chk({tag, ".fault"}, {15'd0, fault}, {15'd0, m_fault});
`ifdef PC16_JUMP_HALT_DETECT_EN
        chk({tag, ".halted"}, {15'd0, halted}, {15'd0, m_halt});
`endif
    endtask

    task automatic idle();
        stall = 1'b0; jmp_en = 1'b0; jmp = 3'b000; zr = 1'b0; ng = 1'b0;
        target = 16'h0000; call = 1'b0; ret = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_taken = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
        m_stk.delete();
    endtask

    // Behaviour of one clock edge given the inputs currently applied.
    task automatic model_step();
        bit lt, eq, gt, go;
        lt = ng; eq = zr; gt = !ng && !zr;
        go = jmp_en && ((jmp[2] && lt) || (jmp[1] && eq) || (jmp[0] && gt));
        if (m_fault) begin
            m_taken = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if ((call && ret) || (ret && m_stk.size() == 0) || (call && m_stk.size() == DEPTH)) begin
            m_fault = 1'b1; m_taken = 1'b0;
        end else if (ret) begin
            m_pc = m_stk.pop_back(); m_taken = 1'b1;
        end else if (call) begin
            m_stk.push_back(m_pc + 16'd1); m_pc = target; m_taken = 1'b1;
        end else if (go) begin
            if (target == m_pc) m_halt = 1'b1;
            m_pc = target; m_taken = 1'b1;
        end else begin
            m_pc = m_pc + 16'd1; m_taken = 1'b0;
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulsed between edges; checked before the next edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        chk({tag, ".pc0"}, pc, 16'h0000);
        reset = 1'b0;
        idle();
    endtask

    task automatic jump_to(input logic [15:0] t);
        idle(); jmp_en = 1'b1; jmp = 3'b111; target = t;
        cycle("jump_to");
        idle();
    endtask

    initial begin
        logic [15:0] frozen;
        idle();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Free-running increment
        for (int i = 1; i <= 3; i++) begin
            cycle("free");
            chk("free.pc", pc, 16'(i));
        end

        // JLT taken / not taken
        jump_to(16'h0005);
        jmp_en = 1'b1; jmp = 3'b100; ng = 1'b1; target = 16'h0040;
        cycle("jlt_taken");
        chk("jlt_taken.pc", pc, 16'h0040);
        jump_to(16'h0005);
        jmp_en = 1'b1; jmp = 3'b100; ng = 1'b0; zr = 1'b0; target = 16'h0040;
        cycle("jlt_not");
        chk("jlt_not.pc", pc, 16'h0006);
        idle();

        // Call then return
        jump_to(16'h0010);
        call = 1'b1; target = 16'h0100;
        cycle("call");
        chk("call.pc", pc, 16'h0100);
        idle();
        for (int i = 0; i < 3; i++) cycle("sub");
        ret = 1'b1;
        cycle("ret");
        chk("ret.pc", pc, 16'h0011);
        chk("ret.empty", {15'd0, stack_empty}, 16'h0001);
        idle();

        // Fill the stack, overflow into fault, stay frozen
        for (int i = 0; i < DEPTH; i++) begin
            call = 1'b1; target = 16'h0200 + 16'(i);
            cycle("fill");
        end
        chk("fill.full", {15'd0, stack_full}, 16'h0001);
        frozen = m_pc;
        cycle("overflow");
        chk("overflow.fault", {15'd0, fault}, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            call = $urandom_range(0, 1) == 1; ret = $urandom_range(0, 1) == 1;
            jmp_en = 1'b1; jmp = 3'b111; target = 16'($urandom);
            cycle("frozen");
            chk("frozen.pc", pc, frozen);
        end
        idle();
        do_reset("reset_fault");

        // Return on empty stack
        ret = 1'b1;
        cycle("ret_empty");
        chk("ret_empty.fault", {15'd0, fault}, 16'h0001);
        do_reset("reset_ret");

        // Wrap at 16'hFFFF
        jump_to(16'hFFFF);
        cycle("wrap");
        chk("wrap.pc", pc, 16'h0000);

        // Stall blocks a call
        jump_to(16'h0033);
        stall = 1'b1; call = 1'b1; target = 16'h0500;
        cycle("stall");
        chk("stall.pc", pc, 16'h0033);
        chk("stall.empty", {15'd0, stack_empty}, 16'h0001);
        idle();

        // Async reset mid-stream
        cycle("pre_async");
        do_reset("async");

`ifdef PC16_JUMP_HALT_DETECT_EN
        jump_to(16'h0020);
        jmp_en = 1'b1; jmp = 3'b111; target = 16'h0020;
        cycle("halt");
        chk("halt.halted", {15'd0, halted}, 16'h0001);
        chk("halt.pc", pc, 16'h0020);
        cycle("halt_loop");
        idle();
        do_reset("reset_halt");
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (m_fault && $urandom_range(0, 3) == 0) begin
                do_reset("rand_reset");
            end
            stall  = $urandom_range(0, 7) == 0;
            call   = $urandom_range(0, 5) == 0;
            ret    = $urandom_range(0, 5) == 0;
            jmp_en = $urandom_range(0, 1) == 1;
            jmp    = 3'($urandom_range(0, 7));
            zr     = $urandom_range(0, 1) == 1;
            ng     = $urandom_range(0, 1) == 1;
            target = ($urandom_range(0, 7) == 0) ? m_pc : 16'($urandom);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc16_jump.md
Name: pc16_jump

Overview:
- Hack-style 16-bit program counter with jump decision, sitting directly downstream of the ALU (whose output stage is the Not16 negation).
- Consumes the ALU zr/ng flags plus the instruction jump bits and selects the next PC: increment, conditional jump, call or return.
- Contains a small return-address stack and a fault state machine, and feeds the instruction ROM address.

Parameters:
- DEPTH, 8: return-stack entries, power of two, 2..64.
- RESET_PC, 16'h0000: PC value after reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold all state this cycle
- jmp_en  in  1  current instruction is a C-instruction (jump bits valid)
- jmp  in  3  {j1,j2,j3}: j1 = out<0, j2 = out==0, j3 = out>0
- zr  in  1  ALU out == 0
- ng  in  1  ALU out < 0
- target  in  16  jump/call destination (A register)
- call  in  1  push pc+1, go to target
- ret  in  1  pop stack into pc
- pc  out  16  current program counter
- taken  out  1  pc was redirected on the previous edge
- stack_empty  out  1  depth count == 0
- stack_full  out  1  depth count == DEPTH
- fault  out  1  sticky stack-error flag

Behaviour:
- Reset (async, any time, including mid-call):
  - pc = RESET_PC, taken = 0, fault = 0.
  - Stack count = 0, so stack_empty = 1 and stack_full = 0.
  - State = RUN. Stack contents are don't-care.
- States: RUN, FAULT.
- RUN, stall = 1: pc, stack and taken all hold. call/ret/jmp are ignored.
- RUN, stall = 0: one action per edge, chosen in this priority order:
  - call & ret together -> FAULT; pc and stack unchanged.
  - ret: if empty -> FAULT. Otherwise pc <= top, pop, taken <= 1.
  - call: if full -> FAULT. Otherwise push (pc+1) mod 2^16, pc <= target, taken <= 1.
  - jump: cond = jmp_en & ((j1&ng) | (j2&zr) | (j3&~ng&~zr)). If cond: pc <= target, taken <= 1.
  - otherwise: pc <= pc+1 (16'hFFFF wraps to 16'h0000), taken <= 0.
- Jump codes: jmp = 3'b000 never jumps; jmp = 3'b111 always jumps when jmp_en = 1.
- Flag conflict: zr & ng together is illegal from the ALU; treat it per the formula, with no special handling.
- FAULT:
  - fault = 1 and pc holds.
  - All inputs are ignored, taken = 0.
  - Exit only via reset.
- Latency: every update takes effect at the next rising edge. No combinational path from inputs to pc.
- Stack:
  - LIFO with a count of width $clog2(DEPTH)+1.
  - stack_full/stack_empty are derived from the registered count.
  - Push and pop never occur in the same cycle.

Optional Feature:
- Macro: PC16_JUMP_HALT_DETECT_EN.
- When defined:
  - Add output halted (1 bit).
  - halted is set on the edge where a taken jump has target == pc (the Hack "@END; 0;JMP" idiom).
  - Once set, halted stays 1 and pc keeps looping normally.
  - Only reset clears it.
- When undefined: no halted port and no extra logic.

Decomposition:
- Package pc16_pkg:
  - state enum typedef {RUN, FAULT}.
  - Jump-code localparams: JGT=3'b001, JEQ=3'b010, JGE=3'b011, JLT=3'b100, JNE=3'b101, JLE=3'b110, JMP=3'b111.
  - Function jump_cond(jmp, zr, ng).
- Sub-module ret_stack:
  - Parameterised LIFO with push, pop, din, dout, count, full and empty.
  - Async reset clears count.

Test Plan:
- Reset, then 3 free-running cycles, stall = 0 -> pc = 0, 1, 2, 3; taken = 0; stack_empty = 1.
- pc = 5, jmp_en = 1, jmp = JLT, ng = 1, target = 16'h0040 -> next pc = 16'h0040, taken = 1. Same stimulus with ng = 0, zr = 0 -> pc = 6.
- call at pc = 16'h0010 with target = 16'h0100, then ret at pc = 16'h0103 -> pc = 16'h0100, then 16'h0011. stack_empty returns to 1.
- DEPTH = 8: 8 calls -> stack_full = 1; a 9th call -> fault = 1, pc frozen for 10 cycles. Apply reset -> pc = 0, fault = 0.
- Boundary sweep:
  - ret when empty -> fault.
  - pc = 16'hFFFF with no jump -> pc = 16'h0000.
  - stall = 1 with call asserted -> pc and count unchanged.
  - Async reset asserted between edges -> pc = 0 immediately.
- With PC16_JUMP_HALT_DETECT_EN: pc = 16'h0020, jmp = JMP, target = 16'h0020 -> halted = 1 after one edge, pc stays 16'h0020.
